// File: rtl/input_port_unit_pkg.sv
// Router-wide output-port codes and flit field offsets, plus the port_t type shared by the input port logic.
`ifndef IPU_GLOBAL_DEFINES
`define IPU_GLOBAL_DEFINES
`define OUT_NONE_PORT  3'b000
`define OUT_LOCAL_PORT 3'b001
`define OUT_X1_PORT    3'b010
`define OUT_X2_PORT    3'b011
`define OUT_Y1_PORT    3'b100
`define FLIT_DSTX_MSB(w) ((w)-1)
`define FLIT_DSTY_BIT(w) ((w)-3)
`endif

package input_port_unit_pkg;
  typedef logic [2:0] port_t;
  localparam port_t PORT_NONE  = `OUT_NONE_PORT;
  localparam port_t PORT_LOCAL = `OUT_LOCAL_PORT;
  localparam port_t PORT_X1    = `OUT_X1_PORT;
  localparam port_t PORT_X2    = `OUT_X2_PORT;
  localparam port_t PORT_Y1    = `OUT_Y1_PORT;
endpackage

// File: rtl/input_port_unit_if.sv
// Upstream flit handshake plus allocator/crossbar-facing signals of one router input port.
interface input_port_unit_if #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
);
  logic                     in_valid;
  logic [FLIT_W-1:0]        in_flit;
  logic                     in_ready;
  logic                     grant;
  logic [FLIT_W-1:0]        head_flit;
  logic [2:0]               port_dst;
  logic [$clog2(DEPTH):0]   count;
  logic                     err_grant_empty;
  logic [15:0]              stall_cnt;

  modport master (
    output in_valid, in_flit, grant,
    input  in_ready, head_flit, port_dst, count, err_grant_empty, stall_cnt
  );

  modport slave (
    input  in_valid, in_flit, grant,
    output in_ready, head_flit, port_dst, count, err_grant_empty, stall_cnt
  );
endinterface

// File: rtl/input_port_unit_route_compute_xy.sv
// Combinational X-then-Y dimension-order route lookup; also used by the local injection path.
module route_compute_xy
  import input_port_unit_pkg::*;
#(
  parameter int    CUR_X   = 0,
  parameter int    CUR_Y   = 0,
  parameter port_t XP_PORT = `OUT_X2_PORT,
  parameter port_t XN_PORT = `OUT_X1_PORT
) (
  input  logic [1:0] dst_x_i,
  input  logic       dst_y_i,
  input  logic       valid_i,
  output port_t      port_dst_o
);
  always_comb begin
    port_dst_o = PORT_NONE;
    if (!valid_i)                     port_dst_o = PORT_NONE;
    else if (dst_x_i > 2'(CUR_X))     port_dst_o = XP_PORT;
    else if (dst_x_i < 2'(CUR_X))     port_dst_o = XN_PORT;
    else if (dst_y_i != 1'(CUR_Y))    port_dst_o = PORT_Y1;
    else                              port_dst_o = PORT_LOCAL;
  end
endmodule

// File: rtl/input_port_unit.sv
// Input port: FIFO + XY route on head, 1-cycle write-to-request, no bypass; in_ready = !full, pop-to-ready 1 cycle.
// IPU_STALL_CNT_EN enables the saturating head-blocked cycle counter on stall_cnt.
module input_port_unit
  import input_port_unit_pkg::*;
#(
  parameter int    FLIT_W  = 32,
  parameter int    DEPTH   = 4,
  parameter int    CUR_X   = 0,
  parameter int    CUR_Y   = 0,
  parameter port_t XP_PORT = `OUT_X2_PORT,
  parameter port_t XN_PORT = `OUT_X1_PORT
) (
  input logic               clk,
  input logic               rst_n,
  input_port_unit_if.slave  ipu
);
  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              err_q, err_d;
  logic              full, empty, push, pop;
  logic [FLIT_W-1:0] head;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = ipu.in_valid && !full;
  assign pop   = ipu.grant && !empty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    err_d    = err_q | (ipu.grant & empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= ipu.in_flit;
  end

  assign head                = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign ipu.head_flit       = head;
  assign ipu.in_ready        = !full;
  assign ipu.count           = wr_ptr_q - rd_ptr_q;
  assign ipu.err_grant_empty = err_q;

  route_compute_xy #(
    .CUR_X   (CUR_X),
    .CUR_Y   (CUR_Y),
    .XP_PORT (XP_PORT),
    .XN_PORT (XN_PORT)
  ) u_route (
    .dst_x_i    (head[`FLIT_DSTX_MSB(FLIT_W) -: 2]),
    .dst_y_i    (head[`FLIT_DSTY_BIT(FLIT_W)]),
    .valid_i    (!empty),
    .port_dst_o (ipu.port_dst)
  );

`ifdef IPU_STALL_CNT_EN
  logic [15:0] stall_q;
  // Cumulative metric: saturates and is never cleared by a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        stall_q <= '0;
    else if (!empty && !ipu.grant && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign ipu.stall_cnt = stall_q;
`else
  assign ipu.stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_input_port_unit.sv
// Directed bench for input_port_unit at router (1,0) with a 4-entry FIFO.
module tb_input_port_unit;
  import input_port_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  input_port_unit_if #(.FLIT_W(32), .DEPTH(4)) bus ();

  input_port_unit #(
    .FLIT_W (32),
    .DEPTH  (4),
    .CUR_X  (1),
    .CUR_Y  (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ipu   (bus)
  );

  function automatic logic [31:0] mk(input logic [1:0] x, input logic y, input logic [28:0] pl);
    return {x, y, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flit(input logic [31:0] f);
    bus.in_valid = 1'b1;
    bus.in_flit  = f;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.grant = 1'b1;
    tick();
    bus.grant = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_flit  = '0;
    bus.grant    = 1'b0;
    rst_n = 1'b0;
    tick();
    n_total++; if (bus.count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.count); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.port_dst !== 3'b000) $display("FAIL reset_port got %0d want 0", bus.port_dst); else n_pass++;
    n_total++; if (bus.head_flit !== 32'h0) $display("FAIL reset_head got %h want 0", bus.head_flit); else n_pass++;
    n_total++; if (bus.err_grant_empty !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err_grant_empty); else n_pass++;
    n_total++; if (bus.stall_cnt !== 16'h0) $display("FAIL reset_stall got %h want 0", bus.stall_cnt); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] f;
    f = mk(2'd3, 1'b0, 29'h0ABC);
    bus.in_valid = 1'b1;
    bus.in_flit  = f;
    #2;
    n_total++; if (bus.port_dst !== 3'b000) $display("FAIL no_bypass got %0d want 0", bus.port_dst); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.port_dst !== 3'b011) $display("FAIL basic_xp got %0d want 3", bus.port_dst); else n_pass++;
    n_total++; if (bus.count !== 3'd1) $display("FAIL basic_count got %0d want 1", bus.count); else n_pass++;
    n_total++; if (bus.head_flit !== f) $display("FAIL basic_head got %h want %h", bus.head_flit, f); else n_pass++;
    pop_one();
    n_total++; if (bus.count !== 3'd0) $display("FAIL basic_pop_count got %0d want 0", bus.count); else n_pass++;
    n_total++; if (bus.port_dst !== 3'b000) $display("FAIL basic_pop_port got %0d want 0", bus.port_dst); else n_pass++;
  endtask

  task automatic test_routing();
    logic [31:0] f [3];
    logic [2:0]  want [3];
    f[0] = mk(2'd0, 1'b0, 29'h11); want[0] = 3'b010;
    f[1] = mk(2'd1, 1'b1, 29'h22); want[1] = 3'b100;
    f[2] = mk(2'd1, 1'b0, 29'h33); want[2] = 3'b001;
    for (int i = 0; i < 3; i++) begin
      write_flit(f[i]);
      n_total++; if (bus.head_flit !== f[i]) $display("FAIL route_head%0d got %h want %h", i, bus.head_flit, f[i]); else n_pass++;
      n_total++; if (bus.port_dst !== want[i]) $display("FAIL route_port%0d got %0d want %0d", i, bus.port_dst, want[i]); else n_pass++;
      tick();
      n_total++; if (bus.port_dst !== want[i]) $display("FAIL route_stable%0d got %0d want %0d", i, bus.port_dst, want[i]); else n_pass++;
      pop_one();
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) write_flit(mk(2'd1, 1'b0, 29'(i)));
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL fill_ready got %b want 0", bus.in_ready); else n_pass++;
    n_total++; if (bus.count !== 3'd4) $display("FAIL fill_count got %0d want 4", bus.count); else n_pass++;
    write_flit(mk(2'd1, 1'b0, 29'd99));
    n_total++; if (bus.count !== 3'd4) $display("FAIL fill_5th got %0d want 4", bus.count); else n_pass++;
    bus.grant    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_flit  = mk(2'd1, 1'b0, 29'd4);
    tick();
    bus.grant = 1'b0;
    n_total++; if (bus.count !== 3'd3) $display("FAIL full_pop_count got %0d want 3", bus.count); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL full_pop_ready got %b want 1", bus.in_ready); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_total++; if (bus.count !== 3'd4) $display("FAIL refill_count got %0d want 4", bus.count); else n_pass++;
    for (int k = 5; k < 12; k++) begin
      n_total++; if (bus.head_flit[28:0] !== 29'(k - 4)) $display("FAIL order%0d got %0d want %0d", k, bus.head_flit[28:0], k - 4); else n_pass++;
      pop_one();
      write_flit(mk(2'd1, 1'b0, 29'(k)));
    end
    for (int k = 8; k < 12; k++) begin
      n_total++; if (bus.head_flit[28:0] !== 29'(k)) $display("FAIL drain%0d got %0d want %0d", k, bus.head_flit[28:0], k); else n_pass++;
      pop_one();
    end
    n_total++; if (bus.count !== 3'd0) $display("FAIL drain_count got %0d want 0", bus.count); else n_pass++;
  endtask

  task automatic test_simultaneous();
    write_flit(mk(2'd2, 1'b0, 29'hA));
    write_flit(mk(2'd0, 1'b0, 29'hB));
    bus.grant    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_flit  = mk(2'd1, 1'b1, 29'hC);
    #1;
    n_total++; if (bus.head_flit[28:0] !== 29'hA) $display("FAIL simul_oldest got %h want A", bus.head_flit[28:0]); else n_pass++;
    tick();
    bus.grant    = 1'b0;
    bus.in_valid = 1'b0;
    n_total++; if (bus.count !== 3'd2) $display("FAIL simul_count got %0d want 2", bus.count); else n_pass++;
    n_total++; if (bus.head_flit[28:0] !== 29'hB) $display("FAIL simul_next got %h want B", bus.head_flit[28:0]); else n_pass++;
    pop_one();
    n_total++; if (bus.port_dst !== 3'b100) $display("FAIL simul_new_port got %0d want 4", bus.port_dst); else n_pass++;
    pop_one();
  endtask

  task automatic test_grant_empty();
    pop_one();
    n_total++; if (bus.err_grant_empty !== 1'b1) $display("FAIL err_set got %b want 1", bus.err_grant_empty); else n_pass++;
    n_total++; if (bus.count !== 3'd0) $display("FAIL err_count got %0d want 0", bus.count); else n_pass++;
    write_flit(mk(2'd3, 1'b1, 29'h51));
    write_flit(mk(2'd3, 1'b1, 29'h52));
    write_flit(mk(2'd3, 1'b1, 29'h53));
    n_total++; if (bus.head_flit[28:0] !== 29'h51) $display("FAIL err_ptr got %h want 51", bus.head_flit[28:0]); else n_pass++;
    n_total++; if (bus.count !== 3'd3) $display("FAIL err_buf got %0d want 3", bus.count); else n_pass++;
    n_total++; if (bus.err_grant_empty !== 1'b1) $display("FAIL err_hold got %b want 1", bus.err_grant_empty); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.count !== 3'd0) $display("FAIL async_count got %0d want 0", bus.count); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL async_ready got %b want 1", bus.in_ready); else n_pass++;
    n_total++; if (bus.err_grant_empty !== 1'b0) $display("FAIL async_err got %b want 0", bus.err_grant_empty); else n_pass++;
    n_total++; if (bus.port_dst !== 3'b000) $display("FAIL async_port got %0d want 0", bus.port_dst); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stall();
    write_flit(mk(2'd1, 1'b0, 29'h77));
    repeat (10) tick();
`ifdef IPU_STALL_CNT_EN
    n_total++; if (bus.stall_cnt !== 16'd10) $display("FAIL stall_10 got %0d want 10", bus.stall_cnt); else n_pass++;
    repeat (70000) tick();
    n_total++; if (bus.stall_cnt !== 16'hFFFF) $display("FAIL stall_sat got %h want FFFF", bus.stall_cnt); else n_pass++;
    pop_one();
    n_total++; if (bus.stall_cnt !== 16'hFFFF) $display("FAIL stall_keep got %h want FFFF", bus.stall_cnt); else n_pass++;
`else
    n_total++; if (bus.stall_cnt !== 16'h0) $display("FAIL stall_off got %h want 0", bus.stall_cnt); else n_pass++;
    pop_one();
    n_total++; if (bus.stall_cnt !== 16'h0) $display("FAIL stall_off_pop got %h want 0", bus.stall_cnt); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_routing();
    test_fill();
    test_simultaneous();
    test_grant_empty();
    test_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
